muldiv_unit: RTL and testbench

- Execute-stage responder to the main decoder's multordiv/hlwrite controls: performs iterative signed 32-bit MULT or DIV and owns the HI/LO registers.
- Started when an EX-stage instruction has hlwrite=1. multordiv=1 selects MULT; multordiv=0 selects DIV.
- Raises busy so the hazard unit stalls IF/ID/EX until the result is written.
- hi/lo are read continuously by the MFHI/MFLO forwarding path.

---
 rtl/muldiv_unit.sv | 117 +++++++++++
 tb/tb_muldiv_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit that owns the HI/LO registers.
// The unit takes one shift-add or shift-subtract step per cycle, working on operand magnitudes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      count;
  logic               is_mult, neg_a, neg_b, div_zero;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc, step_acc, prod_fixed;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign mag_a  = srca[WIDTH-1] ? -srca : srca;
  assign mag_b  = srcb[WIDTH-1] ? -srcb : srcb;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MULT: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  // DIV: shift the next dividend bit into the remainder and keep the subtraction if it does not borrow.
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, b_mag};
    if (is_mult)
      step_acc = {add_sum, acc_lo[WIDTH-1:1]};
    else if (diff[WIDTH])
      step_acc = {shifted[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    else
      step_acc = {diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
  end

  // A zero divisor leaves the quotient all ones and the remainder equal to |srca|,
  // so restoring the dividend sign reproduces srca exactly.
  always_comb begin
    prod_fixed = (neg_a ^ neg_b) ? -acc : acc;
    if (is_mult) begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end else begin
      fix_hi = neg_a ? -acc_hi : acc_hi;
      fix_lo = div_zero ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_mult  <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_mult  <= multordiv;
          neg_a    <= srca[WIDTH-1];
          neg_b    <= srcb[WIDTH-1];
          div_zero <= (srcb == '0);
          b_mag    <= multordiv ? mag_a : mag_b;
          acc      <= {{WIDTH{1'b0}}, (multordiv ? mag_b : mag_a)};
          count    <= '0;
        end
        CALC: begin
          acc   <= step_acc;
          count <= count + CW'(1);
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit timing (busy/done windows) and HI/LO results.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset, start, multordiv;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          check_count = 0;
  int          fail_count  = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .multordiv(multordiv),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference: 64-bit signed arithmetic, so -2^31 / -1 cannot overflow.
  function automatic logic [63:0] refResult(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) return sa * sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Entered at posedge+1; leaves at posedge+1 of the done cycle so a following call starts back-to-back.
  task automatic applyStimulus(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic repulse);
    int          busy_cycles, done_cycle;
    logic        stable;
    logic [31:0] hi0, lo0;
    busy_cycles = 0;
    done_cycle  = 0;
    stable      = 1'b1;
    start = 1'b1; multordiv = op; srca = a; srcb = b;
    hi0 = hi; lo0 = lo;
    @(posedge clk); #1;
    start = 1'b0; multordiv = ~op; srca = ~a; srcb = a ^ b;
    for (int c = 1; c <= 40; c++) begin
      if (repulse && c == 5) begin
        start = 1'b1; srca = 32'h0000_1234; srcb = 32'h0000_0005; multordiv = ~op;
      end
      if (repulse && c == 6) start = 1'b0;
      if (done) begin
        done_cycle = c;
        break;
      end
      if (busy) busy_cycles++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput({tag, ".done_at"}, 64'(done_cycle), 64'd34);
    checkOutput({tag, ".busy_len"}, 64'(busy_cycles), 64'd33);
    checkOutput({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    checkOutput({tag, ".hilo_stable"}, 64'(stable), 64'd1);
    checkOutput({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    logic [63:0] exp_v;
    logic [31:0] ra, rb;
    logic        rop, saw_done;

    reset = 1'b1; start = 1'b0; multordiv = 1'b0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.hi", 64'(hi), 64'd0);
    checkOutput("rst.lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus("mul_5x6", 1'b1, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0);

    // Abort a multiply ten cycles into its run.
    start = 1'b1; multordiv = 1'b1; srca = 32'd7; srcb = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.done", 64'(done), 64'd0);
    checkOutput("abort.hi", 64'(hi), 64'd0);
    checkOutput("abort.lo", 64'(lo), 64'd0);
    #2 reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort.no_done", 64'(saw_done), 64'd0);
    checkOutput("abort.hi_kept", 64'(hi), 64'd0);
    checkOutput("abort.lo_kept", 64'(lo), 64'd0);

    applyStimulus("mul_7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    applyStimulus("mul_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    applyStimulus("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    applyStimulus("div_1234_0", 1'b0, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("div_m5_0", 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("div_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    applyStimulus("div_m100_m7", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0);
    applyStimulus("repulse", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      rop   = 1'($urandom_range(0, 1));
      ra    = pickOperand();
      rb    = pickOperand();
      exp_v = refResult(rop, ra, rb);
      applyStimulus($sformatf("rnd%0d", i), rop, ra, rb, exp_v[63:32], exp_v[31:0], 1'b0);
    end

    @(posedge clk); #1;
    checkOutput("done_width", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", check_count, fail_count);
    $finish;
  end
endmodule
